// File: rtl/div_seq.sv
// Restoring divider for RV64M DIV/DIVU/REM/REMU (+W): one quotient bit per cycle,
// with each trial subtraction performed on an external ALU instance.
//   state  | meaning
//   IDLE   | ready for a request; special cases resolve here
//   PREP   | take operand magnitudes, record result signs, load shifter
//   ITER   | one trial subtraction per cycle, N cycles
//   FIX    | apply signs, select quotient/remainder, register result
//   DONE   | result valid, held until accepted
module div_seq #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic            is_w,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [2:0]      alu_sel,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic            alu_sub_sra,
  output logic            alu_is_op_x_32,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_smaller_u
);
  localparam int HALF = XLEN / 2;
  localparam int CW   = $clog2(XLEN);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;

  state_t          r_state, w_next;
  logic [1:0]      r_op;
  logic            r_is_w;
  logic [XLEN-1:0] r_a, r_b, r_quo, r_rem, r_out_data;
  logic            r_sign_q, r_sign_r;
  logic [CW-1:0]   r_cnt;

  function automatic logic [XLEN-1:0] sext_half(input logic [HALF-1:0] v);
    return {{HALF{v[HALF-1]}}, v};
  endfunction

  logic            w_signed, w_accept, w_div_zero, w_ovf, w_special;
  logic [XLEN-1:0] w_src1_x, w_src2_x, w_spec_raw, w_spec_res;

  assign w_signed = ~op[0];
  assign w_src1_x = is_w ? (w_signed ? sext_half(src1[HALF-1:0]) : {{HALF{1'b0}}, src1[HALF-1:0]}) : src1;
  assign w_src2_x = is_w ? (w_signed ? sext_half(src2[HALF-1:0]) : {{HALF{1'b0}}, src2[HALF-1:0]}) : src2;
  assign w_div_zero = is_w ? (src2[HALF-1:0] == '0) : (src2 == '0);
  // most-negative / -1 at the active width
  assign w_ovf = w_signed &
                 (is_w ? (src1[HALF-1:0] == {1'b1, {(HALF-1){1'b0}}}) : (src1 == {1'b1, {(XLEN-1){1'b0}}})) &
                 (is_w ? (&src2[HALF-1:0]) : (&src2));
  assign w_special  = w_div_zero | w_ovf;
  assign w_spec_raw = w_div_zero ? (op[1] ? src1 : '1) : (op[1] ? '0 : src1);
  assign w_spec_res = is_w ? sext_half(w_spec_raw[HALF-1:0]) : w_spec_raw;

  assign in_ready = (r_state == S_IDLE) & ~flush;
  assign w_accept = in_valid & in_ready;
  assign out_valid = (r_state == S_DONE);
  assign out_data  = r_out_data;

  logic            w_sgn_a, w_sgn_b;
  logic [XLEN-1:0] w_mag_a, w_mag_b;

  assign w_sgn_a = ~r_op[0] & r_a[XLEN-1];
  assign w_sgn_b = ~r_op[0] & r_b[XLEN-1];
  assign w_mag_a = w_sgn_a ? -r_a : r_a;
  assign w_mag_b = w_sgn_b ? -r_b : r_b;

  logic            w_iter, w_rc, w_take;
  logic [XLEN-1:0] w_trial;

  assign w_iter  = (r_state == S_ITER);
  assign w_trial = {r_rem[XLEN-2:0], r_quo[XLEN-1]};
  // a set shifted-out bit means the trial value already exceeds any divisor
  assign w_rc    = r_rem[XLEN-1];
  assign w_take  = w_rc | ~alu_smaller_u;

  assign alu_sel        = 3'b000;
  assign alu_is_op_x_32 = 1'b0;
  assign alu_sub_sra    = w_iter;
  assign alu_a          = w_iter ? w_trial : '0;
  assign alu_b          = w_iter ? r_b : '0;

  logic [XLEN-1:0] w_q, w_r, w_sel, w_fix_res;

  assign w_q       = r_sign_q ? -r_quo : r_quo;
  assign w_r       = r_sign_r ? -r_rem : r_rem;
  assign w_sel     = r_op[1] ? w_r : w_q;
  assign w_fix_res = r_is_w ? sext_half(w_sel[HALF-1:0]) : w_sel;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = w_special ? S_DONE : S_PREP;
      S_PREP: w_next = S_ITER;
      S_ITER: if (r_cnt == '0) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (flush && r_state != S_IDLE) w_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op       <= '0;
      r_is_w     <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_quo      <= '0;
      r_rem      <= '0;
      r_sign_q   <= 1'b0;
      r_sign_r   <= 1'b0;
      r_cnt      <= '0;
      r_out_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_op   <= op;
          r_is_w <= is_w;
          r_a    <= w_src1_x;
          r_b    <= w_src2_x;
          if (w_special) r_out_data <= w_spec_res;
        end
        S_PREP: begin
          r_sign_q <= w_sgn_a ^ w_sgn_b;
          r_sign_r <= w_sgn_a;
          r_b      <= w_mag_b;
          r_quo    <= r_is_w ? (w_mag_a << HALF) : w_mag_a;
          r_rem    <= '0;
          r_cnt    <= r_is_w ? CW'(HALF - 1) : CW'(XLEN - 1);
        end
        S_ITER: begin
          r_rem <= w_take ? alu_result : w_trial;
          r_quo <= {r_quo[XLEN-2:0], w_take};
          r_cnt <= r_cnt - 1'b1;
        end
        S_FIX: if (!flush) r_out_data <= w_fix_res;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: RV64M reference model plus cycle-level handshake model,
// checked every cycle, with directed vectors carrying hand-computed results.
module tb_div_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [1:0]  op = 2'b00;
  logic        is_w = 1'b0;
  logic [63:0] src1 = '0, src2 = '0;
  logic        flush = 1'b0;
  logic        out_valid, out_ready = 1'b0;
  logic [63:0] out_data;
  logic [2:0]  alu_sel;
  logic [63:0] alu_a, alu_b, alu_result;
  logic        alu_sub_sra, alu_is_op_x_32, alu_smaller_u;

  int n_tests = 0;
  int n_fail  = 0;
  int sra_cnt = 0;
  bit chk_en  = 1'b0;

  localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

  div_seq #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .is_w(is_w), .src1(src1), .src2(src2), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_sub_sra(alu_sub_sra),
    .alu_is_op_x_32(alu_is_op_x_32), .alu_result(alu_result), .alu_smaller_u(alu_smaller_u)
  );

  always #5 clk = ~clk;

  // external ALU
  assign alu_result    = alu_sub_sra ? alu_a - alu_b : alu_a + alu_b;
  assign alu_smaller_u = alu_a < alu_b;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic w,
                                             input logic [63:0] a, input logic [63:0] b);
    logic        sg;
    logic [31:0] a32, b32, q32, r32, res32;
    int          sa32, sb32;
    longint      sa, sb;
    logic [63:0] q, r;
    sg = !o[0];
    if (w) begin
      a32 = a[31:0];
      b32 = b[31:0];
      if (b32 == 0) begin
        q32 = '1; r32 = a32;
      end else if (sg && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        q32 = a32; r32 = 0;
      end else if (sg) begin
        sa32 = a32; sb32 = b32;
        q32 = sa32 / sb32; r32 = sa32 % sb32;
      end else begin
        q32 = a32 / b32; r32 = a32 % b32;
      end
      res32 = o[1] ? r32 : q32;
      return {{32{res32[31]}}, res32};
    end
    if (b == 0) begin
      q = '1; r = a;
    end else if (sg && a == 64'h8000_0000_0000_0000 && b == '1) begin
      q = a; r = 0;
    end else if (sg) begin
      sa = a; sb = b;
      q = sa / sb; r = sa % sb;
    end else begin
      q = a / b; r = a % b;
    end
    return o[1] ? r : q;
  endfunction

  function automatic bit is_special(input logic [1:0] o, input logic w,
                                    input logic [63:0] a, input logic [63:0] b);
    if (w) return (b[31:0] == 0) || (!o[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
    return (b == 0) || (!o[0] && a == 64'h8000_0000_0000_0000 && b == '1);
  endfunction

  function automatic logic [63:0] divisor_mag(input logic [1:0] o, input logic w, input logic [63:0] b);
    longint v;
    if (w) v = o[0] ? longint'({32'b0, b[31:0]}) : longint'(int'(b[31:0]));
    else   v = b;
    if (!o[0] && v < 0) v = -v;
    return v;
  endfunction

  // transaction model: remaining cycles until the result is due
  bit          m_busy = 1'b0, m_special = 1'b0, m_w = 1'b0;
  int          m_cnt = 0;
  logic [63:0] m_data = '0, m_mag_b = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
    end else if (m_busy) begin
      if (flush) m_busy <= 1'b0;
      else if (m_cnt == 0) begin
        if (out_ready) m_busy <= 1'b0;
      end else m_cnt <= m_cnt - 1;
    end else if (in_valid && !flush) begin
      m_busy    <= 1'b1;
      m_special <= is_special(op, is_w, src1, src2);
      m_w       <= is_w;
      m_cnt     <= is_special(op, is_w, src1, src2) ? 0 : (is_w ? 34 : 66);
      m_data    <= ref_result(op, is_w, src1, src2);
      m_mag_b   <= divisor_mag(op, is_w, src2);
    end
  end

  always @(negedge clk) begin
    bit it;
    if (chk_en) begin
      check("in_ready", in_ready, !m_busy && !flush);
      check("out_valid", out_valid, m_busy && m_cnt == 0);
      if (m_busy && m_cnt == 0) check("out_data", out_data, m_data);
      // iteration cycles sit between PREP and FIX
      it = m_busy && !m_special && m_cnt >= 2 && m_cnt <= (m_w ? 33 : 65);
      check("alu_sub_sra", alu_sub_sra, it);
      check("alu_b", alu_b, it ? m_mag_b : 64'd0);
      if (!it) check("alu_a_idle", alu_a, 64'd0);
      check("alu_sel", alu_sel, 3'b000);
      check("alu_is_op_x_32", alu_is_op_x_32, 1'b0);
      if (alu_sub_sra) sra_cnt++;
    end
  end

  task automatic start_op(input logic [1:0] o, input logic w, input logic [63:0] a, input logic [63:0] b);
    @(posedge clk); #1;
    op = o; is_w = w; src1 = a; src2 = b; in_valid = 1'b1; out_ready = 1'b0;
    sra_cnt = 0;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run(input string nm, input logic [1:0] o, input logic w,
                     input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] exp_val, input int exp_lat, input int stall);
    int cyc;
    cyc = 0;
    start_op(o, w, a, b);
    for (int i = 1; i <= 200 && cyc == 0; i++) begin
      @(negedge clk);
      if (out_valid) cyc = i;
    end
    check({nm, "_lat"}, cyc, exp_lat);
    check({nm, "_val"}, out_data, exp_val);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({nm, "_hold_rdy"}, in_ready, 1'b0);
      check({nm, "_hold_val"}, out_data, exp_val);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    check({nm, "_sra_cycles"}, sra_cnt, exp_lat == 1 ? 0 : exp_lat - 3);
    @(negedge clk);
    check({nm, "_back_idle"}, in_ready, 1'b1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_in_ready", in_ready, 1'b1);

    run("divu_100_7",  DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 67, 0);
    run("remu_100_7",  REMU, 1'b0, 64'd100, 64'd7, 64'd2, 67, 0);
    run("div_m7_2",    DIV,  1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 67, 0);
    run("rem_m7_2",    REM,  1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 67, 0);
    run("rem_7_m2",    REM,  1'b0, 64'd7, -64'sd2, 64'd1, 67, 0);
    run("div_by0",     DIV,  1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    run("remu_by0",    REMU, 1'b0, 64'h1234, 64'd0, 64'h1234, 1, 0);
    run("div_ovf",     DIV,  1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1, 0);
    run("rem_ovf",     REM,  1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1, 0);
    run("divw_ovf",    DIV,  1'b1, 64'h0000_0000_8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 1, 0);
    run("divuw_ff_1",  DIVU, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 35, 0);
    run("divw_m100_7", DIV,  1'b1, 64'h0000_0000_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 35, 0);
    run("remw_m100_7", REM,  1'b1, 64'h0000_0000_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 35, 0);
    run("remuw_hi",    REMU, 1'b1, 64'hDEAD_0000_0000_0064, 64'hBEEF_0000_0000_0007, 64'd2, 35, 0);
    run("divu_big",    DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'd1, 67, 0);
    run("backpress",   DIVU, 1'b0, 64'd1000, 64'd10, 64'd100, 67, 10);

    // flush in IDLE blocks acceptance
    @(posedge clk); #1;
    op = DIVU; is_w = 1'b0; src1 = 64'd5; src2 = 64'd1; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    check("idle_flush_rdy", in_ready, 1'b0);
    @(posedge clk); #1 in_valid = 1'b0; flush = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("idle_flush_noresult", out_valid, 1'b0);
    end

    // flush during the 20th iteration
    start_op(DIVU, 1'b0, 64'd1000, 64'd3);
    repeat (20) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("flush_valid", out_valid, 1'b0);
    check("flush_ready", in_ready, 1'b1);
    run("divu_9_3_a", DIVU, 1'b0, 64'd9, 64'd3, 64'd3, 67, 0);

    // synchronous reset mid-iteration
    start_op(DIV, 1'b0, -64'sd1000, 64'd3);
    repeat (30) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", out_valid, 1'b0);
    check("rst_mid_ready", in_ready, 1'b1);
    check("rst_mid_data", out_data, 64'd0);
    run("divu_9_3_b", DIVU, 1'b0, 64'd9, 64'd3, 64'd3, 67, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
